// File: rtl/key_matrix_scanner.sv
// 8x8 key matrix scanner: active-low row scan, per-key debounce counters,
// and a show-ahead valid/ready FIFO of press/release events.
module key_matrix_scanner #(
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned SCAN_HZ        = 1000000,
    parameter int unsigned DEBOUNCE_SCANS = 16,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic        sysclk,
    input  logic        rst_n,
    output logic [7:0]  row_drive,
    input  logic [7:0]  col_sense,
    output logic        event_valid,
    input  logic        event_ready,
    output logic [2:0]  event_row,
    output logic [2:0]  event_col,
    output logic        event_press,
    output logic [63:0] key_state,
    output logic        overflow
);
    localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned DW  = $clog2(DIV);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_SCANS - 1);

    if (DIV < 12) begin : g_div_check
        $error("key_matrix_scanner: CLK_HZ/SCAN_HZ must be at least 12");
    end
    if (DEBOUNCE_SCANS < 2 || DEBOUNCE_SCANS > 255) begin : g_deb_check
        $error("key_matrix_scanner: DEBOUNCE_SCANS must be in 2..255");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fifo_check
        $error("key_matrix_scanner: FIFO_DEPTH must be a power of 2, at least 2");
    end

    typedef enum logic {IDLE, SCAN} state_t;

    logic [7:0]    col_meta, col_sync;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [2:0]    row, scan_row, col;
    logic [7:0]    snap;
    state_t        state;
    logic [7:0]    cnt [64];
    logic [5:0]    key;
    logic          differ, settle, push;
    logic [6:0]    push_data;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= col_sense;
            col_sync <= col_meta;
        end
    end

    assign tick = (div_cnt == DW'(DIV - 1));

    // Columns are captured at the end of the dwell, long after the synchronizer has settled.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            row       <= '0;
            scan_row  <= '0;
            snap      <= '0;
            row_drive <= 8'hFE;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            if (tick) begin
                snap      <= ~col_sync;
                scan_row  <= row;
                row       <= row + 3'd1;
                row_drive <= ~(8'd1 << (row + 3'd1));
            end
        end
    end

    always_comb begin
        key       = {scan_row, col};
        differ    = (snap[col] != key_state[key]);
        settle    = (cnt[key] == CNT_MAX);
        push      = (state == SCAN) && differ && settle;
        push_data = {scan_row, col, ~key_state[key]};
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            col       <= '0;
            key_state <= '0;
            for (int unsigned i = 0; i < 64; i++) cnt[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= SCAN;
                        col   <= '0;
                    end
                end
                SCAN: begin
                    if (!differ) begin
                        cnt[key] <= '0;
                    end else if (settle) begin
                        key_state[key] <= ~key_state[key];
                        cnt[key]       <= '0;
                    end else begin
                        cnt[key] <= cnt[key] + 8'd1;
                    end
                    col <= col + 3'd1;
                    if (col == 3'd7) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [6:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, wr_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && event_ready;
    // A pop frees the slot being overwritten, so a full FIFO still accepts a push.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + (AW + 1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (AW + 1)'(1);
            if (push && !wr_en) overflow <= 1'b1;
        end
    end

    assign event_valid = !empty;
    assign {event_row, event_col, event_press} = event_valid ? mem[rd_ptr[AW-1:0]] : 7'd0;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench for key_matrix_scanner: frame-level debounce and event-queue
// model compared every cycle, plus hand-computed event and state expectations.
module tb_key_matrix_scanner;
    localparam int unsigned DIV   = 50;
    localparam int unsigned FRAME = 8 * DIV;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DEB   = 16;

    logic        sysclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  row_drive;
    logic [7:0]  col_sense;
    logic        event_valid;
    logic        event_ready = 1'b0;
    logic [2:0]  event_row, event_col;
    logic        event_press;
    logic [63:0] key_state;
    logic        overflow;

    logic [63:0] phys = '0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    key_matrix_scanner #(
        .CLK_HZ(50000000),
        .SCAN_HZ(1000000),
        .DEBOUNCE_SCANS(DEB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .sysclk(sysclk),
        .rst_n(rst_n),
        .row_drive(row_drive),
        .col_sense(col_sense),
        .event_valid(event_valid),
        .event_ready(event_ready),
        .event_row(event_row),
        .event_col(event_col),
        .event_press(event_press),
        .key_state(key_state),
        .overflow(overflow)
    );

    always #5 sysclk = ~sysclk;

    // Pressed keys pull their column low only while their row is driven.
    always_comb begin
        col_sense = 8'hFF;
        for (int r = 0; r < 8; r++)
            if (row_drive[r] == 1'b0) col_sense = col_sense & ~phys[r*8 +: 8];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    int unsigned n = 0;
    logic [63:0] m_keys = '0;
    int unsigned m_run [64];
    logic [7:0]  m_snap = '0;
    logic        m_ovf = 1'b0;
    logic [6:0]  m_q [$];
    logic [6:0]  dut_log [$];

    always @(posedge sysclk) begin : model
        int unsigned r, c, k;
        logic [7:0] exp_row;
        if (!rst_n) begin
            n = 0;
            m_keys = '0;
            m_ovf = 1'b0;
            m_snap = '0;
            m_q.delete();
            for (int i = 0; i < 64; i++) m_run[i] = 0;
        end else begin
            if (event_valid && event_ready)
                dut_log.push_back({event_row, event_col, event_press});
            if (m_q.size() != 0 && event_ready) void'(m_q.pop_front());
            n++;
            if (n > DIV && n % DIV >= 1 && n % DIV <= 8) begin
                c = n % DIV - 1;
                r = (n / DIV - 1) % 8;
                k = r * 8 + c;
                if (m_snap[c] == m_keys[k]) begin
                    m_run[k] = 0;
                end else begin
                    m_run[k]++;
                    if (m_run[k] == DEB) begin
                        m_keys[k] = ~m_keys[k];
                        m_run[k] = 0;
                        if (m_q.size() < DEPTH) m_q.push_back({3'(r), 3'(c), m_keys[k]});
                        else m_ovf = 1'b1;
                    end
                end
            end
            if (n % DIV == 0) begin
                r = (n / DIV - 1) % 8;
                m_snap = phys[r*8 +: 8];
            end
        end
        #1;
        exp_row = ~(8'd1 << ((n / DIV) % 8));
        check("row_drive", 64'(row_drive), 64'(exp_row));
        check("event_valid", 64'(event_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0)
            check("event_head", 64'({event_row, event_col, event_press}), 64'(m_q[0]));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("key_state", key_state, m_keys);
    end

    task automatic frames(input int unsigned f);
        repeat (f * FRAME) @(negedge sysclk);
    endtask

    task automatic wait_phase(input int unsigned ph);
        int unsigned guard = 0;
        while (n % FRAME != ph && guard < 2 * FRAME) begin
            @(negedge sysclk);
            guard++;
        end
        check("phase_reached", 64'(n % FRAME), 64'(ph));
    endtask

    task automatic check_log(input int unsigned idx, input logic [6:0] exp);
        if (dut_log.size() > idx) check($sformatf("event_%0d", idx), 64'(dut_log[idx]), 64'(exp));
        else check($sformatf("event_%0d_missing", idx), 64'(dut_log.size()), 64'(idx + 1));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge sysclk);
        check("reset_row_drive", 64'(row_drive), 64'h00000000000000FE);
        check("reset_valid", 64'(event_valid), 64'd0);
        check("reset_fields", 64'({event_row, event_col, event_press}), 64'd0);
        check("reset_key_state", key_state, 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        event_ready = 1'b1;
        wait_phase(10);

        // single press / release of key (2,5)
        phys[21] = 1'b1;
        frames(DEB);
        check("press_count", 64'(dut_log.size()), 64'd1);
        check_log(0, {3'd2, 3'd5, 1'b1});
        check("press_key21", 64'(key_state[21]), 64'd1);
        phys[21] = 1'b0;
        frames(DEB);
        check("release_count", 64'(dut_log.size()), 64'd2);
        check_log(1, {3'd2, 3'd5, 1'b0});
        check("release_key21", 64'(key_state[21]), 64'd0);

        // bounce: 15 pressed, 1 released, 15 pressed
        phys[21] = 1'b1;
        frames(DEB - 1);
        phys[21] = 1'b0;
        frames(1);
        phys[21] = 1'b1;
        frames(DEB - 1);
        phys[21] = 1'b0;
        check("bounce_count", 64'(dut_log.size()), 64'd2);
        check("bounce_key21", 64'(key_state[21]), 64'd0);
        frames(1);

        // full row 3 press, then release
        phys[31:24] = 8'hFF;
        frames(DEB);
        check("row_press_count", 64'(dut_log.size()), 64'd10);
        for (int c = 0; c < 8; c++) check_log(2 + c, {3'd3, 3'(c), 1'b1});
        check("row_press_keys", 64'(key_state[31:24]), 64'hFF);
        phys[31:24] = 8'h00;
        frames(DEB);
        check("row_release_count", 64'(dut_log.size()), 64'd18);
        check("row_release_keys", key_state, 64'd0);

        // backpressure: only cols 0..3 fit, the rest are dropped
        event_ready = 1'b0;
        phys[31:24] = 8'hFF;
        frames(DEB);
        check("bp_overflow", 64'(overflow), 64'd1);
        check("bp_valid", 64'(event_valid), 64'd1);
        check("bp_head", 64'({event_row, event_col, event_press}), 64'({3'd3, 3'd0, 1'b1}));
        check("bp_keys", 64'(key_state[31:24]), 64'hFF);
        repeat (5) @(negedge sysclk);
        check("bp_head_hold", 64'({event_row, event_col, event_press}), 64'({3'd3, 3'd0, 1'b1}));
        event_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge sysclk);
            check("drain_rate", 64'(dut_log.size()), 64'(19 + i));
            check_log(18 + i, {3'd3, 3'(i), 1'b1});
        end
        check("drain_empty", 64'(event_valid), 64'd0);
        event_ready = 1'b0;

        // async reset with three events queued mid-scan of row 4
        wait_phase(10);
        phys[34:32] = 3'b111;
        frames(DEB - 1);
        wait_phase(5 * DIV + 4);
        check("pre_reset_valid", 64'(event_valid), 64'd1);
        check("pre_reset_head", 64'({event_row, event_col, event_press}), 64'({3'd4, 3'd0, 1'b1}));
        check("pre_reset_keys", 64'(key_state[34:32]), 64'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 64'(event_valid), 64'd0);
        check("async_key_state", key_state, 64'd0);
        check("async_overflow", 64'(overflow), 64'd0);
        check("async_row_drive", 64'(row_drive), 64'h00000000000000FE);
        phys = '0;
        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
        repeat (FRAME) @(negedge sysclk);
        check("final_key_state", key_state, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
